// File: rtl/panda_data_mem_arbiter.sv
// panda_data_mem_arbiter
// Shares one req/gnt/rvalid memory port between the load store unit (port 0)
// and instruction fetch (port 1). At most one transaction is outstanding.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no transaction; pick a winner and present its address phase
// WAIT_GNT | address phase presented, memory has not granted; owner locked
// RESP     | address phase accepted; waiting for the memory response
module panda_data_mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ROUND_ROBIN = 0
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [1:0]                          req_i,
  input  logic [1:0][ADDR_WIDTH-1:0]          addr_i,
  input  logic [1:0]                          we_i,
  input  logic [1:0][DATA_WIDTH/8-1:0]        be_i,
  input  logic [1:0][DATA_WIDTH-1:0]          wdata_i,
  output logic [1:0]                          gnt_o,
  output logic [1:0]                          rvalid_o,
  output logic [DATA_WIDTH-1:0]               rdata_o,
  output logic                                err_o,
  output logic                                mem_req_o,
  output logic [ADDR_WIDTH-1:0]               mem_addr_o,
  output logic                                mem_we_o,
  output logic [DATA_WIDTH/8-1:0]             mem_be_o,
  output logic [DATA_WIDTH-1:0]               mem_wdata_o,
  input  logic                                mem_gnt_i,
  input  logic                                mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]               mem_rdata_i,
  input  logic                                mem_err_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    RESP     = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;
  logic   winner;
  logic   sel;

  // Winner selection: a lone requester always wins; ties go to port 0, or to
  // the port that did not win last time when round robin is enabled.
  always_comb begin
    if (req_i == 2'b11) begin
      winner = (ROUND_ROBIN != 0) ? ~last_grant_q : 1'b0;
    end else begin
      winner = req_i[1] & ~req_i[0];
    end
  end

  // State, owner and round-robin history registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    sel          = owner_q;
    gnt_o        = 2'b00;
    rvalid_o     = 2'b00;
    rdata_o      = '0;
    err_o        = 1'b0;
    mem_req_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          mem_req_o = 1'b1;
          sel       = winner;
          owner_d   = winner;
          if (mem_gnt_i) begin
            gnt_o[winner] = 1'b1;
            last_grant_d  = winner;
            state_d       = RESP;
          end else begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        // The other port is never considered here; the owner either gets
        // its grant or withdraws and the transaction is dropped silently.
        if (req_i[owner_q]) begin
          mem_req_o = 1'b1;
          if (mem_gnt_i) begin
            gnt_o[owner_q] = 1'b1;
            last_grant_d   = owner_q;
            state_d        = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (mem_rvalid_i) begin
          rvalid_o[owner_q] = 1'b1;
          rdata_o           = mem_rdata_i;
          err_o             = mem_err_i;
          state_d           = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address-phase mux; fields are forced to zero when no request is issued.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      mem_addr_o  = addr_i[sel];
      mem_we_o    = we_i[sel];
      mem_be_o    = be_i[sel];
      mem_wdata_o = wdata_i[sel];
    end
  end

endmodule
